// File: rtl/recip_share_ctrl.sv
// Shares one single-issue reciprocal unit among NUM_REQ requesters: round-robin accept,
// hold the operand stable for the whole computation, and return the captured result tagged with its id.
module recip_share_ctrl #(
    parameter int WIDTH     = 32,
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int RECIP_LAT = 4,
    parameter int CNT_W     = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]         recip_a,
    input  logic [WIDTH-1:0]         recip_r,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, HOLD, RESP} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr, id_reg, win_id, idx;
    logic              win_found;
    logic [CNT_W-1:0]  hold_cnt;
    logic [WIDTH-1:0]  op_reg;
    int                idx_i;

    // Round-robin search starting at rr_ptr; only the winner's operand is ever read.
    always_comb begin
        win_found = 1'b0;
        win_id    = rr_ptr;
        idx_i     = 0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_i = (int'(rr_ptr) + k) % NUM_REQ;
            idx   = ID_W'(idx_i);
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt = HOLD;
                    if (!rst) req_ready[win_id] = 1'b1;
                end
            end
            HOLD: if (hold_cnt == CNT_W'(RECIP_LAT)) state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id_reg    <= '0;
            hold_cnt  <= '0;
            op_reg    <= '0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        op_reg   <= req_data[win_id*WIDTH +: WIDTH];
                        id_reg   <= win_id;
                        rr_ptr   <= ID_W'((int'(win_id) + 1) % NUM_REQ);
                        hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    hold_cnt <= hold_cnt + CNT_W'(1);
                    // Mantissa path has drained RECIP_LAT stages: result is now coherent.
                    if (hold_cnt == CNT_W'(RECIP_LAT)) begin
                        rsp_data  <= recip_r;
                        rsp_id    <= id_reg;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign recip_a = op_reg;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_recip_share_ctrl.sv
// Randomized bench for recip_share_ctrl: a timing-level arbiter model predicts grants and
// response windows; a separate monitor checks returned results against a scoreboard queue.
module tb_recip_share_ctrl;
    localparam int W = 32, N = 4, IW = 2, LAT = 4, CW = 3;
    localparam logic [W-1:0] FMASK = 32'h7F000000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req_valid, req_ready;
    logic [N*W-1:0]       req_data;
    logic [W-1:0]         recip_a, recip_r, rsp_data;
    logic                 rsp_valid, rsp_ready, busy;
    logic [IW-1:0]        rsp_id;

    recip_share_ctrl #(.WIDTH(W), .NUM_REQ(N), .ID_W(IW), .RECIP_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .recip_a(recip_a), .recip_r(recip_r), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy));

    always #5 clk = ~clk;

    // Reciprocal stub: f(a) = a ^ 0x7F000000 after LAT register stages.
    logic [W-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= recip_a ^ FMASK;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign recip_r = pipe[LAT-1];

    typedef struct { logic [IW-1:0] id; logic [W-1:0] data; } exp_t;
    exp_t q[$];

    int checks = 0, errors = 0, cyc = 0;
    bit           m_inflight = 0;
    int           m_rr = 0, m_rsp_at = 0;
    logic [W-1:0] m_op = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] rand_data();
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) d[i*W +: W] = $urandom;
        return d;
    endfunction

    // One clock: drive inputs after the edge, check and advance the model mid-cycle.
    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d, input bit rr);
        logic [N-1:0] exp_ready;
        bit           exp_valid, found;
        int           g;
        @(posedge clk);
        #1;
        req_valid = v; req_data = d; rsp_ready = rr;
        @(negedge clk);
        exp_ready = '0; found = 0; g = 0;
        if (!m_inflight) begin
            for (int k = 0; k < N; k++) begin
                if (!found && v[(m_rr + k) % N]) begin
                    found = 1; g = (m_rr + k) % N;
                end
            end
            if (found) exp_ready[g] = 1'b1;
        end
        exp_valid = m_inflight && (cyc >= m_rsp_at);
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("busy", 64'(busy), 64'(m_inflight));
        chk("recip_a", 64'(recip_a), 64'(m_op));
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
        if (found) begin
            q.push_back('{id: IW'(g), data: d[g*W +: W] ^ FMASK});
            m_op = d[g*W +: W];
            m_rr = (g + 1) % N;
            m_inflight = 1;
            m_rsp_at = cyc + LAT + 2;
        end else if (exp_valid && rr) begin
            m_inflight = 0;
        end
        cyc++;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_recip_a", 64'(recip_a), 64'd0);
        q.delete();
        m_inflight = 0; m_rr = 0; m_op = '0;
        req_valid = '0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: every cycle a response is presented it must match the oldest outstanding op.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                chk("rsp_data", 64'(rsp_data), 64'(q[0].data));
                chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
                if (rsp_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        logic [N*W-1:0] d;
        rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
        #1;
        chk("init_busy", 64'(busy), 64'd0);
        chk("init_rsp_valid", 64'(rsp_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single op from requester 1: 0x40000000 -> 0x3F000000
        d = rand_data();
        d[1*W +: W] = 32'h40000000;
        step(4'b0010, d, 1'b1);
        repeat (8) step(4'b0000, rand_data(), 1'b1);

        // Fairness from a fresh pointer
        do_reset();
        repeat (36) step(4'b1111, rand_data(), 1'b1);

        // Backpressure in RESP
        repeat (6) step(4'b1111, rand_data(), 1'b1);
        repeat (14) step(4'b1111, rand_data(), 1'b0);
        repeat (10) step(4'b1111, rand_data(), 1'b1);

        // Reset while hold_cnt==2, then 0 and 2 requesting: 0 wins
        do_reset();
        step(4'b0100, rand_data(), 1'b1);
        repeat (3) step(4'b0000, rand_data(), 1'b1);
        do_reset();
        repeat (10) step(4'b0101, rand_data(), 1'b1);

        // Skip idle requesters: pointer at 1, only 3 valid; then 0 and 3 valid
        do_reset();
        step(4'b0001, rand_data(), 1'b1);
        repeat (7) step(4'b0000, rand_data(), 1'b1);
        step(4'b1000, rand_data(), 1'b1);
        repeat (7) step(4'b0000, rand_data(), 1'b1);
        repeat (8) step(4'b1001, rand_data(), 1'b1);

        // Random traffic with random backpressure and occasional mid-op resets
        for (int n = 0; n < 600; n++) begin
            step(N'($urandom), rand_data(), ($urandom_range(0, 9) < 7));
            if ($urandom_range(0, 99) == 0) do_reset();
        end
        repeat (20) step(4'b0000, rand_data(), 1'b1);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
